regfile_ctrl: RTL and testbench

//  Command-driven initiator for the 8x16 regfile write/read ports (data_in/writenum/write, readnum/data_out).

---
 rtl/rf_ctrl_pkg.sv | 24 ++
 rtl/regfile_ctrl.sv | 178 +++++++++++++++++
 tb/tb_regfile_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types for regfile_ctrl: command opcodes, controller states, register count.
// S_VFY exists only when RF_WRITE_VERIFY_EN is defined.
package rf_ctrl_pkg;

  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_MOV   = 2'b01,
    OP_READ  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
`ifdef RF_WRITE_VERIFY_EN
    S_VFY  = 3'd4,
`endif
    S_RSP  = 3'd3
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command-driven initiator for the 8x16 regfile ports: LOADI/MOV/READ/DUMP in, read data out.
// Optional write-verify step with a sticky wr_err flag is enabled by RF_WRITE_VERIFY_EN.
module regfile_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_idx,
  output logic              rsp_last,
  output logic              wr_err,
  output logic [2:0]        state_dbg
);

  // Both streams use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the producer keeps valid and payload stable until that edge.

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((1 << ADDR_W) - 1);

  state_e            state, state_n;
  op_e               op_q, op_n;
  logic [ADDR_W-1:0] rd_q, rd_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] data_in_n, rsp_data_n;
  logic [ADDR_W-1:0] writenum_n, readnum_n, rsp_idx_n;
  logic              write_n, rsp_valid_n, rsp_last_n;
  logic              accept;

`ifdef RF_WRITE_VERIFY_EN
  logic err_q, err_n;
`endif

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    rd_n        = rd_q;
    cnt_n       = cnt;
    data_in_n   = rf_data_in;
    writenum_n  = rf_writenum;
    write_n     = 1'b0;
    readnum_n   = rf_readnum;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_idx_n   = rsp_idx;
    rsp_last_n  = rsp_last;
`ifdef RF_WRITE_VERIFY_EN
    err_n       = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_n = op_e'(cmd_op);
          rd_n = cmd_rd;
          case (op_e'(cmd_op))
            OP_LOADI: begin
              writenum_n = cmd_rd;
              data_in_n  = cmd_imm;
              write_n    = 1'b1;
              state_n    = S_WR;
            end
            OP_MOV, OP_READ: begin
              readnum_n = cmd_rs;
              state_n   = S_RD;
            end
            default: begin
              cnt_n     = '0;
              readnum_n = '0;
              state_n   = S_RD;
            end
          endcase
        end
      end
      S_RD: begin
        if (op_q == OP_MOV) begin
          data_in_n  = rf_data_out;
          writenum_n = rd_q;
          write_n    = 1'b1;
          state_n    = S_WR;
        end else begin
          // rf_readnum already holds rs (READ) or cnt (DUMP), so it doubles as the index
          rsp_data_n  = rf_data_out;
          rsp_idx_n   = rf_readnum;
          rsp_last_n  = (op_q == OP_READ) || (cnt == LAST_IDX);
          rsp_valid_n = 1'b1;
          state_n     = S_RSP;
        end
      end
      S_WR: begin
`ifdef RF_WRITE_VERIFY_EN
        readnum_n = rf_writenum;
        state_n   = S_VFY;
`else
        state_n   = S_IDLE;
`endif
      end
`ifdef RF_WRITE_VERIFY_EN
      S_VFY: begin
        err_n   = err_q | (rf_data_out != rf_data_in);
        state_n = S_IDLE;
      end
`endif
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          if (rsp_last) begin
            state_n = S_IDLE;
          end else begin
            cnt_n     = cnt + 1'b1;
            readnum_n = cnt + 1'b1;
            state_n   = S_RD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= OP_LOADI;
      rd_q        <= '0;
      cnt         <= '0;
      rf_data_in  <= '0;
      rf_writenum <= '0;
      rf_write    <= 1'b0;
      rf_readnum  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_idx     <= '0;
      rsp_last    <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      rd_q        <= rd_n;
      cnt         <= cnt_n;
      rf_data_in  <= data_in_n;
      rf_writenum <= writenum_n;
      rf_write    <= write_n;
      rf_readnum  <= readnum_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      rsp_idx     <= rsp_idx_n;
      rsp_last    <= rsp_last_n;
    end
  end

`ifdef RF_WRITE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
  assign wr_err = err_q;
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x16 regfile attached to the rf_* ports.
// Covers RF_WRITE_VERIFY_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_regfile_ctrl;
  import rf_ctrl_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
`ifdef RF_WRITE_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd, cmd_rs;
  logic [DATA_W-1:0] cmd_imm;
  logic [DATA_W-1:0] rf_data_in, rf_data_out;
  logic [ADDR_W-1:0] rf_writenum, rf_readnum;
  logic              rf_write;
  logic              rsp_valid, rsp_ready, rsp_last, wr_err;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_idx;
  logic [2:0]        state_dbg;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] regs [NREGS];
  logic force_zero = 1'b0;

  regfile_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_idx(rsp_idx), .rsp_last(rsp_last), .wr_err(wr_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / regfile model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write) regs[rf_writenum] <= rf_data_in;
  end

  always_comb begin
    rf_data_out = regs[rf_readnum];
`ifdef RF_WRITE_VERIFY_EN
    if (force_zero && state_dbg == S_VFY) rf_data_out = '0;
`endif
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input op_e op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [15:0] imm);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    checks++;
    if ({rf_data_in, rf_writenum, rf_write, rf_readnum, rsp_valid, rsp_data, rsp_idx,
         rsp_last, wr_err, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: data_in=%h wn=%h w=%b rn=%h rv=%b rd=%h ri=%h rl=%b err=%b st=%h required all 0",
               rf_data_in, rf_writenum, rf_write, rf_readnum, rsp_valid, rsp_data, rsp_idx,
               rsp_last, wr_err, state_dbg);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_loadi_read();
    int wc = 0;
    bit ok;
    send_cmd(OP_LOADI, 3'd3, 3'd0, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rf_write === 1'b1) wc++;
      if (i == 0) begin
        checks++;
        if (rf_write !== 1'b1 || rf_writenum !== 3'd3 || rf_data_in !== 16'hBEEF) begin
          failures++;
          $display("FAIL loadi_port: w=%b wn=%0d din=%h required w=1 wn=3 din=beef",
                   rf_write, rf_writenum, rf_data_in);
        end
      end
    end
    checks++;
    if (wc != 1) begin
      failures++; $display("FAIL loadi_pulse: rf_write high %0d cycles, required 1", wc);
    end
    send_cmd(OP_READ, 3'd0, 3'd3, 16'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_data !== 16'hBEEF || rsp_idx !== 3'd3 || rsp_last !== 1'b1) begin
      failures++;
      $display("FAIL read_r3: valid=%b data=%h idx=%0d last=%b required 1 beef 3 1",
               rsp_valid, rsp_data, rsp_idx, rsp_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_mov();
    int n = 0;
    bit ok;
    logic [2:0]  ridx [3] = '{3'd5, 3'd1, 3'd2};
    logic [15:0] rexp [3] = '{16'h0006, 16'h0006, 16'h1234};
    send_cmd(OP_LOADI, 3'd1, 3'd0, 16'h0006);
    send_cmd(OP_MOV, 3'd5, 3'd1, 16'h0);
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 2 + VFY) begin
      failures++; $display("FAIL mov_busy: cmd_ready low %0d cycles, required %0d", n, 2 + VFY);
    end
    send_cmd(OP_LOADI, 3'd2, 3'd0, 16'h1234);
    send_cmd(OP_MOV, 3'd2, 3'd2, 16'h0);
    for (int i = 0; i < 3; i++) begin
      send_cmd(OP_READ, 3'd0, ridx[i], 16'h0);
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_data !== rexp[i] || rsp_idx !== ridx[i]) begin
        failures++;
        $display("FAIL mov_read[%0d]: valid=%b data=%h idx=%0d required %h %0d",
                 i, rsp_valid, rsp_data, rsp_idx, rexp[i], ridx[i]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_dump();
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    bit t = 1'b1;
    bit stalled = 1'b0;
    logic [15:0] exp_d, held_d;
    logic [2:0]  held_i;
    for (int n = 0; n < NREGS; n++) begin
      send_cmd(OP_LOADI, 3'(n), 3'd0, 16'h0100 + 16'(n));
      exp_q.push_back(16'h0100 + 16'(n));
    end
    send_cmd(OP_DUMP, 3'd0, 3'd0, 16'h0);
    while (got < NREGS && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (stalled) begin
          checks++;
          if (rsp_data !== held_d || rsp_idx !== held_i) begin
            failures++;
            $display("FAIL dump_stall_stable: data=%h idx=%0d required %h %0d",
                     rsp_data, rsp_idx, held_d, held_i);
          end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
          failures++; $display("FAIL dump_ready_early: cmd_ready=%b required 0 at idx %0d", cmd_ready, got);
        end
        rsp_ready = t;
        if (t) begin
          exp_d = exp_q.pop_front();
          checks++;
          if (rsp_data !== exp_d || rsp_idx !== 3'(got) || rsp_last !== (got == NREGS - 1)) begin
            failures++;
            $display("FAIL dump_rsp[%0d]: data=%h idx=%0d last=%b required %h %0d %b",
                     got, rsp_data, rsp_idx, rsp_last, exp_d, got, got == NREGS - 1);
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          stalls++;
          held_d = rsp_data;
          held_i = rsp_idx;
        end
        t = ~t;
      end else begin
        rsp_ready = 1'b1;
      end
    end
    checks++;
    if (got != NREGS || stalls == 0) begin
      failures++; $display("FAIL dump_count: responses=%0d stalls=%0d required 8 and >0", got, stalls);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_done: cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int acc = 0;
    int bad = 0;
    int wr_seen = 0;
    int acc_at [2] = '{0, 0};
    bit ok;
    @(negedge clk);
    cmd_op = OP_MOV; cmd_rd = 3'd6; cmd_rs = 3'd5; cmd_imm = 16'h0; cmd_valid = 1'b1;
    while (acc < 2 && cyc < 50) begin
      if (rf_write) begin
        wr_seen++;
        if (state_dbg !== S_WR) bad++;
      end
      if (cmd_ready) begin
        acc_at[acc] = cyc;
        acc++;
        @(posedge clk);
        #1;
        if (acc == 1) begin
          cmd_op = OP_LOADI; cmd_rd = 3'd7; cmd_imm = 16'hAAAA;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      if (rf_write) begin
        wr_seen++;
        if (state_dbg !== S_WR) bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (acc != 2 || acc_at[1] - acc_at[0] != 3 + VFY) begin
      failures++;
      $display("FAIL b2b_accept_gap: accepts=%0d gap=%0d required 2 and %0d",
               acc, acc_at[1] - acc_at[0], 3 + VFY);
    end
    checks++;
    if (bad != 0 || wr_seen != 2) begin
      failures++;
      $display("FAIL b2b_write_pulses: outside_wr=%0d writes=%0d required 0 and 2", bad, wr_seen);
    end
    send_cmd(OP_READ, 3'd0, 3'd6, 16'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_data !== 16'h0105) begin
      failures++; $display("FAIL b2b_read_r6: data=%h required 0105", rsp_data);
    end
    @(posedge clk);
    send_cmd(OP_READ, 3'd0, 3'd7, 16'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_data !== 16'hAAAA) begin
      failures++; $display("FAIL b2b_read_r7: data=%h required aaaa", rsp_data);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_dump();
    int cyc = 0;
    bit hit = 1'b0;
    bit ok;
    rsp_ready = 1'b1;
    send_cmd(OP_DUMP, 3'd0, 3'd0, 16'h0);
    while (!hit && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid && rsp_idx == 3'd2) begin
        rsp_ready = 1'b0;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL mid_dump_reach: idx 2 response not seen, rsp_idx=%0d", rsp_idx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL ready_in_reset: cmd_ready=%b required 0", cmd_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_dump_reset: rsp_valid=%b cmd_ready=%b rsp_last=%b required 0 1 0",
               rsp_valid, cmd_ready, rsp_last);
    end
    rsp_ready = 1'b1;
    send_cmd(OP_READ, 3'd0, 3'd0, 16'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_data !== 16'h0100 || rsp_idx !== 3'd0 || rsp_last !== 1'b1) begin
      failures++;
      $display("FAIL read_after_reset: data=%h idx=%0d last=%b required 0100 0 1",
               rsp_data, rsp_idx, rsp_last);
    end
    @(posedge clk);
  endtask

`ifdef RF_WRITE_VERIFY_EN
  task automatic test_write_verify();
    checks++;
    if (wr_err !== 1'b0) begin
      failures++; $display("FAIL verify_clean: wr_err=%b required 0", wr_err);
    end
    force_zero = 1'b1;
    send_cmd(OP_LOADI, 3'd4, 3'd0, 16'h00FF);
    repeat (4) @(negedge clk);
    force_zero = 1'b0;
    checks++;
    if (wr_err !== 1'b1) begin
      failures++; $display("FAIL verify_flag: wr_err=%b required 1", wr_err);
    end
    send_cmd(OP_LOADI, 3'd4, 3'd0, 16'h0055);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_err !== 1'b1) begin
      failures++; $display("FAIL verify_sticky: wr_err=%b required 1", wr_err);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_err !== 1'b0) begin
      failures++; $display("FAIL verify_reset_clear: wr_err=%b required 0", wr_err);
    end
  endtask
`else
  task automatic test_wr_err_tied();
    checks++;
    if (wr_err !== 1'b0) begin
      failures++; $display("FAIL wr_err_tied: wr_err=%b required 0", wr_err);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_loadi_read();
    test_mov();
    test_dump();
    test_back_to_back();
    test_reset_mid_dump();
`ifdef RF_WRITE_VERIFY_EN
    test_write_verify();
`else
    test_wr_err_tied();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
